// File: rtl/matrix_row_fetch.sv
// matrix_row_fetch: fetches NUM_ROWS 64-bit rows over Avalon-MM and hands them to a consumer one at a time
module matrix_row_fetch #(
  parameter int          NUM_ROWS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [63:0] readdata,
  input  logic        readdatavalid,
  output logic [63:0] row_data,
  output logic [4:0]  row_idx,
  output logic        row_valid,
  input  logic        row_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [4:0]    LAST  = 5'(NUM_ROWS - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, PRESENT, FINISH} state_t;
  state_t        state;
  logic [4:0]    cnt;
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tcnt      <= '0;
      address   <= '0;
      read      <= 1'b0;
      row_data  <= '0;
      row_idx   <= '0;
      row_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt     <= '0;
          error   <= 1'b0;
          busy    <= 1'b1;
          read    <= 1'b1;
          address <= BASE_ADDR;
          state   <= ISSUE;
        end
        ISSUE: if (!waitrequest) begin
          read  <= 1'b0;
          tcnt  <= '0;
          state <= WAIT_DATA;
        end
        WAIT_DATA: if (readdatavalid) begin
          row_data  <= readdata;
          row_idx   <= cnt;
          row_valid <= 1'b1;
          state     <= PRESENT;
        end else if (tcnt == TLAST) begin
          error <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= FINISH;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        PRESENT: if (row_ready) begin
          row_valid <= 1'b0;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            cnt     <= cnt + 1'b1;
            read    <= 1'b1;
            address <= BASE_ADDR + {27'd0, cnt + 5'd1};
            state   <= ISSUE;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_row_fetch.sv
// tb_matrix_row_fetch: directed bench with a latency-12 slave model and a wrapped-address second instance
module tb_matrix_row_fetch;
  logic clk = 0, reset_n = 0, start = 0, start2 = 0;
  logic [31:0] address, address2;
  logic read, read2, waitrequest;
  logic waitrequest2 = 0, row_ready2 = 1;
  logic [63:0] readdata = 0, readdata2 = 0, row_data, row_data2;
  logic readdatavalid = 0, readdatavalid2 = 0;
  logic [4:0] row_idx, row_idx2;
  logic row_valid, row_valid2, row_ready, busy, busy2, done, done2, error, error2;
  logic [31:0] stall_addr = 32'hDEAD_0000, drop_addr = 32'hDEAD_0000;
  logic [4:0] hold_idx = 5'd31;
  int st = 0, cd = 0, cd2 = 0, hold_cnt = 0;
  logic [7:0] raddr = 0, raddr2 = 0;
  logic [31:0] acc_q[$], acc2_q[$];
  logic [4:0] idx_q[$], idx2_q[$];
  logic [63:0] dat_q[$], dat2_q[$];
  int rd2_cnt = 0, hold_seen = 0, viol = 0, done_cnt = 0, done2_cnt = 0;
  int errors = 0, checks = 0;
  int na, ni, nd, na2, ni2, nd2;

  always #5 clk = ~clk;

  matrix_row_fetch u0 (.clk(clk), .reset_n(reset_n), .start(start), .address(address), .read(read),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid), .row_data(row_data),
    .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready), .busy(busy), .done(done), .error(error));

  matrix_row_fetch #(.NUM_ROWS(4), .BASE_ADDR(32'hFFFF_FFFE)) u2 (.clk(clk), .reset_n(reset_n), .start(start2),
    .address(address2), .read(read2), .waitrequest(waitrequest2), .readdata(readdata2),
    .readdatavalid(readdatavalid2), .row_data(row_data2), .row_idx(row_idx2), .row_valid(row_valid2),
    .row_ready(row_ready2), .busy(busy2), .done(done2), .error(error2));

  assign waitrequest = read && address == stall_addr && st < 3;
  assign row_ready = !(row_valid && row_idx == hold_idx && hold_cnt < 20);

  // slave models: each response is {8{address[7:0]}}, drop_addr is never answered
  always @(posedge clk) begin
    st <= (read && waitrequest) ? st + 1 : 0;
    if (row_valid && !row_ready) hold_cnt <= hold_cnt + 1;
    if (read && !waitrequest && address != drop_addr) begin
      cd <= 12;
      raddr <= address[7:0];
    end else if (cd != 0) cd <= cd - 1;
    readdatavalid <= (cd == 1);
    readdata <= {8{raddr}};
    if (read2 && !waitrequest2) begin
      cd2 <= 2;
      raddr2 <= address2[7:0];
    end else if (cd2 != 0) cd2 <= cd2 - 1;
    readdatavalid2 <= (cd2 == 1);
    readdata2 <= {8{raddr2}};
  end

  always @(negedge clk) begin
    if (read && !waitrequest) acc_q.push_back(address);
    if (read && address == 32'd2) rd2_cnt++;
    if (row_valid && row_ready) begin
      idx_q.push_back(row_idx);
      dat_q.push_back(row_data);
    end
    if (row_valid && !row_ready) begin
      hold_seen++;
      if (row_idx != 5'd4 || row_data != {8{8'h04}} || read) viol++;
    end
    if (done) begin
      done_cnt++;
      if (busy) viol++;
    end
    if (read2 && !waitrequest2) acc2_q.push_back(address2);
    if (row_valid2) begin
      idx2_q.push_back(row_idx2);
      dat2_q.push_back(row_data2);
    end
    if (done2) done2_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mark();
    na = acc_q.size(); ni = idx_q.size(); nd = done_cnt;
    na2 = acc2_q.size(); ni2 = idx2_q.size(); nd2 = done2_cnt;
  endtask

  task automatic go();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_done(input bit two, input int lim);
    int n = 0;
    int d0 = two ? done2_cnt : done_cnt;
    while ((two ? done2_cnt : done_cnt) == d0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if ((two ? done2_cnt : done_cnt) == d0) check("wait_done", 0, 1);
    @(negedge clk);
  endtask

  task automatic check_rows(input int nrows, input int nacc);
    logic [7:0] b;
    check("nrows", idx_q.size() - ni, nrows);
    check("naccept", acc_q.size() - na, nacc);
    for (int i = 0; i < nrows && ni + i < idx_q.size(); i++) begin
      b = 8'(i);
      check("row_idx", idx_q[ni+i], i);
      check("row_data", dat_q[ni+i], {8{b}});
    end
    for (int i = 0; i < nacc && na + i < acc_q.size(); i++) check("address", acc_q[na+i], i);
  endtask

  task automatic wait_accepts(input int n);
    int k = 0;
    while (acc_q.size() - na < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (acc_q.size() - na < n) check("wait_accept", 0, 1);
  endtask

  initial begin
    int k;
    logic [31:0] ea[4];
    #1;
    check("rst_read", read, 0);
    check("rst_address", address, 0);
    check("rst_row_valid", row_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    repeat (3) @(negedge clk);
    reset_n = 1;
    // eight rows in order with no back-pressure
    mark(); go(); wait_done(0, 2000);
    check_rows(8, 8);
    check("done_pulses", done_cnt - nd, 1);
    check("error_clean", error, 0);
    check("busy_end", busy, 0);
    // waitrequest held on row 2
    stall_addr = 32'd2;
    mark(); k = rd2_cnt; go(); wait_done(0, 2000);
    check_rows(8, 8);
    check("stall_hold", rd2_cnt - k, 4);
    stall_addr = 32'hDEAD_0000;
    // consumer stalls row 4
    hold_idx = 5'd4;
    mark(); k = hold_seen; go(); wait_done(0, 3000);
    check_rows(8, 8);
    check("hold_cycles", hold_seen - k, 20);
    check("hold_stable", viol, 0);
    hold_idx = 5'd31;
    // row 3 never answered -> timeout
    drop_addr = 32'd3;
    mark(); go(); wait_done(0, 2000);
    check_rows(3, 4);
    check("to_error", error, 1);
    check("to_busy", busy, 0);
    check("to_done", done_cnt - nd, 1);
    drop_addr = 32'hDEAD_0000;
    mark(); go();
    check("err_clear", error, 0);
    wait_done(0, 2000);
    check_rows(8, 8);
    check("err_after", error, 0);
    // reset while waiting for row 5
    mark(); go(); wait_accepts(6);
    repeat (3) @(negedge clk);
    #2 reset_n = 0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_read", read, 0);
    check("ar_address", address, 0);
    check("ar_row_data", row_data, 0);
    check("ar_row_idx", row_idx, 0);
    check("ar_row_valid", row_valid, 0);
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (20) @(negedge clk);
    check("stale_valid", row_valid, 0);
    check("stale_busy", busy, 0);
    check("stale_rows", idx_q.size() - ni, 5);
    check("abort_done", done_cnt - nd, 0);
    mark(); go(); wait_done(0, 2000);
    check_rows(8, 8);
    // start while busy and during FINISH
    mark(); go(); wait_accepts(4);
    go();
    k = 0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!done) check("finish_seen", 0, 1);
    start = 1;
    @(negedge clk) start = 0;
    repeat (5) @(negedge clk);
    check("fin_busy", busy, 0);
    check("fin_read", read, 0);
    check_rows(8, 8);
    check("fin_done", done_cnt - nd, 1);
    // wrapped base address on the 4-row instance
    ea = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    mark();
    @(negedge clk) start2 = 1;
    @(negedge clk) start2 = 0;
    wait_done(1, 500);
    check("w_naccept", acc2_q.size() - na2, 4);
    check("w_nrows", idx2_q.size() - ni2, 4);
    for (int i = 0; i < 4 && na2 + i < acc2_q.size(); i++) check("w_address", acc2_q[na2+i], ea[i]);
    for (int i = 0; i < 4 && ni2 + i < idx2_q.size(); i++) begin
      check("w_idx", idx2_q[ni2+i], i);
      check("w_data", dat2_q[ni2+i], {8{ea[i][7:0]}});
    end
    check("w_done", done2_cnt - nd2, 1);
    check("w_error", error2, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
